// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the RS(255,239) encoder: field constants,
// generator coefficients and the constant-multiply helper.
package rs_pkg;

  localparam int unsigned N     = 255;
  localparam int unsigned K     = 239;
  localparam int unsigned T     = 8;
  localparam int unsigned M     = 8;
  localparam int unsigned NPAR  = 2 * T;
  localparam int unsigned CNT_W = $clog2(K);
  localparam int          FCR   = 0;
  localparam logic [8:0]  PRIM_POLY = 9'h11D;

  typedef enum logic {
    MSG    = 1'b0,
    PARITY = 1'b1
  } state_e;

  typedef logic [M-1:0]       sym_t;
  typedef sym_t [NPAR-1:0]    coef_arr_t;

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < int'(M); i++) begin
      if (b[i]) p ^= x;
      x = x[M-1] ? (sym_t'({x[M-2:0], 1'b0}) ^ PRIM_POLY[M-1:0])
                 : sym_t'({x[M-2:0], 1'b0});
    end
    return p;
  endfunction

  // g(x) = prod (x - a^(FCR+i)); monic, so only the low NPAR coefficients are kept
  function automatic coef_arr_t calc_gen_coef();
    sym_t      g [NPAR+1];
    sym_t      root;
    coef_arr_t res;
    g[0] = sym_t'(1);
    for (int j = 1; j <= int'(NPAR); j++) g[j] = '0;
    root = sym_t'(1);
    for (int i = 0; i < FCR + int'(NPAR); i++) begin
      if (i >= FCR) begin
        for (int j = int'(NPAR); j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
        g[0] = gf_mul(g[0], root);
      end
      root = gf_mul(root, sym_t'(2));
    end
    for (int j = 0; j < int'(NPAR); j++) res[j] = g[j];
    return res;
  endfunction

  localparam coef_arr_t GEN_COEF = calc_gen_coef();

endpackage

// File: rtl/gf_mul_const.sv
// Multiply a GF(2^8) symbol by a fixed constant; folds to a pure XOR network.
module gf_mul_const
  import rs_pkg::*;
#(
  parameter sym_t COEF = '0
) (
  input  logic [M-1:0] a_i,
  output logic [M-1:0] y_o
);

  assign y_o = gf_mul(a_i, COEF);

endmodule

// File: rtl/rs_encoder_stream.sv
// Streaming systematic RS(255,239) encoder: message passes through, then
// 16 LFSR parity symbols follow, with one registered valid/ready output stage.
module rs_encoder_stream
  import rs_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_sof,
  output logic         out_eof,
  output logic         out_parity
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  coef_arr_t         r_q, r_d;
  logic              out_valid_q, out_valid_d;
  sym_t              out_data_q, out_data_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eof_q, out_eof_d;
  logic              out_parity_q, out_parity_d;

  sym_t      fb;
  coef_arr_t prod;
  logic      adv;
  logic      accept;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = !rst_in && (state_q == MSG) && adv;
  assign accept   = in_valid && in_ready;
  assign fb       = in_data ^ r_q[NPAR-1];

  for (genvar gi = 0; gi < int'(NPAR); gi++) begin : g_mul
    gf_mul_const #(.COEF(GEN_COEF[gi])) u_mul (
      .a_i (fb),
      .y_o (prod[gi])
    );
  end

  // Next-state and output-stage update
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    r_d          = r_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sof_d    = out_sof_q;
    out_eof_d    = out_eof_q;
    out_parity_d = out_parity_q;
    case (state_q)
      MSG: begin
        if (accept) begin
          r_d[0] = prod[0];
          for (int i = 1; i < int'(NPAR); i++) r_d[i] = r_q[i-1] ^ prod[i];
          out_data_d   = in_data;
          out_valid_d  = 1'b1;
          out_sof_d    = (cnt_q == '0);
          out_eof_d    = 1'b0;
          out_parity_d = 1'b0;
          if (cnt_q == CNT_W'(K - 1)) begin
            cnt_d   = '0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (adv) begin
          out_valid_d = 1'b0;
        end
      end
      PARITY: begin
        if (adv) begin
          out_data_d   = r_q[NPAR-1];
          out_valid_d  = 1'b1;
          out_sof_d    = 1'b0;
          out_parity_d = 1'b1;
          out_eof_d    = (cnt_q == CNT_W'(NPAR - 1));
          r_d[0]       = '0;
          for (int i = 1; i < int'(NPAR); i++) r_d[i] = r_q[i-1];
          if (cnt_q == CNT_W'(NPAR - 1)) begin
            cnt_d   = '0;
            state_d = MSG;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= MSG;
      cnt_q        <= '0;
      r_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_parity_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      r_q          <= r_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      out_parity_q <= out_parity_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign out_parity = out_parity_q;

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Directed/random bench for rs_encoder_stream with an expected-symbol queue.
module tb_rs_encoder_stream;
  import rs_pkg::*;

  localparam int NN = 255;
  localparam int KK = 239;
  localparam int NP = 16;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       out_parity;

  rs_encoder_stream dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_parity (out_parity)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       par;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  msg_buf [2*KK];
  logic [7:0]  got_cw  [NN];
  logic [7:0]  gb      [NP+1];
  int          got_n;
  int          tests;
  int          fails;
  bit          prev_stall;
  logic [10:0] prev_out;
  int          cyc;
  int          last_eof_cyc;
  int          frames_seen;
  bit          chk_b2b;
  bit          chk_rdy;
  int          rdy_low;

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Long division of m(x)*x^16 by g(x); pushes one expected entry per output symbol
  task automatic encode_frame(input int f, input bit use_gen);
    logic [7:0] p [NN];
    logic [7:0] c;
    exp_t       e;
    for (int i = 0; i < NN; i++) p[i] = (i < KK) ? msg_buf[f*KK + i] : 8'h00;
    for (int i = 0; i < KK; i++) begin
      c = p[i];
      for (int e2 = 0; e2 < NP; e2++) p[i + NP - e2] ^= tb_mul(c, gb[e2]);
    end
    for (int i = 0; i < NN; i++) begin
      if (i < KK) begin
        e = '{d: msg_buf[f*KK + i], sof: (i == 0), eof: 1'b0, par: 1'b0};
      end else begin
        e = '{d: use_gen ? GEN_COEF[NN-1-i] : p[i], sof: 1'b0, eof: (i == NN-1), par: 1'b1};
      end
      q.push_back(e);
    end
  endtask

  task automatic mon();
    exp_t       e;
    logic [7:0] a;
    logic [7:0] s;
    cyc++;
    if (prev_stall)
      check("stall_hold", {21'd0, out_valid, out_data, out_sof, out_eof, out_parity},
            {21'd0, 1'b1, prev_out});
    if (out_valid && out_ready) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_out observed=%0h expected=none", out_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        check("symbol", {21'd0, out_data, out_sof, out_eof, out_parity}, {21'd0, e});
      end
      if (out_sof) begin
        got_n = 0;
        if (chk_b2b && frames_seen > 0) check("b2b_start", cyc, last_eof_cyc + 1);
      end
      if (got_n < NN) got_cw[got_n] = out_data;
      got_n++;
      if (out_eof) begin
        check("frame_len", got_n, NN);
        a = 8'h01;
        for (int r = 0; r < NP; r++) begin
          s = 8'h00;
          for (int i = 0; i < NN; i++) s = tb_mul(s, a) ^ got_cw[i];
          check("syndrome", {24'd0, s}, 32'd0);
          a = tb_mul(a, 8'h02);
        end
        last_eof_cyc = cyc;
        frames_seen++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_data, out_sof, out_eof, out_parity};
    if (chk_rdy) begin
      if (!in_ready) rdy_low++;
      else begin
        if (rdy_low > 0) check("ready_low_len", rdy_low, NP);
        rdy_low = 0;
      end
    end
  endtask

  task automatic step(output bit acc);
    @(negedge clk_in);
    acc = in_valid && in_ready;
    mon();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int nfr, input int gap, input int bp, input bit use_gen);
    int i;
    int budget;
    bit acc;
    for (int f = 0; f < nfr; f++) encode_frame(f, use_gen);
    i = 0;
    budget = nfr * NN * 20;
    rdy_low = 0;
    while (i < nfr*KK || q.size() != 0) begin
      in_valid  = (i < nfr*KK) && (int'($urandom_range(99)) >= gap);
      in_data   = in_valid ? msg_buf[i] : 8'($urandom);
      out_ready = (int'($urandom_range(99)) >= bp);
      step(acc);
      if (acc) i++;
      budget--;
      if (budget == 0) begin
        check("timeout", q.size(), 0);
        q.delete();
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic fill_unit();
    for (int i = 0; i < KK; i++) msg_buf[i] = (i == KK-1) ? 8'h01 : 8'h00;
  endtask

  task automatic fill_rand(input int nfr);
    for (int i = 0; i < nfr*KK; i++) msg_buf[i] = 8'($urandom);
  endtask

  initial begin
    bit acc;
    int i;
    logic [7:0] root;
    tests = 0; fails = 0; got_n = 0; cyc = 0; last_eof_cyc = 0; frames_seen = 0;
    prev_stall = 1'b0; prev_out = '0; chk_b2b = 1'b0; chk_rdy = 1'b0; rdy_low = 0;
    rst_in = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;

    gb[0] = 8'h01;
    for (int j = 1; j <= NP; j++) gb[j] = 8'h00;
    root = 8'h01;
    for (int r = 0; r < NP; r++) begin
      for (int j = NP; j > 0; j--) gb[j] = gb[j-1] ^ tb_mul(gb[j], root);
      gb[0] = tb_mul(gb[0], root);
      root = tb_mul(root, 8'h02);
    end

    repeat (3) @(posedge clk_in);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_flags", {29'd0, out_sof, out_eof, out_parity}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    rst_in = 1'b0;
    step(acc);

    // all-zero message
    chk_rdy = 1'b1;
    for (int j = 0; j < KK; j++) msg_buf[j] = 8'h00;
    send(1, 0, 0, 1'b0);

    // single unit symbol at the lowest message degree
    fill_unit();
    send(1, 0, 0, 1'b1);

    // random messages, no stalls
    fill_rand(1);
    send(1, 0, 0, 1'b0);
    fill_rand(1);
    send(1, 10, 0, 1'b0);

    // random input gaps and output backpressure
    chk_rdy = 1'b0;
    fill_rand(1);
    send(1, 30, 40, 1'b0);
    fill_rand(1);
    send(1, 50, 60, 1'b0);

    // reset mid-frame
    fill_rand(1);
    encode_frame(0, 1'b0);
    i = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (i < 100) begin
      in_data = msg_buf[i];
      step(acc);
      if (acc) i++;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 1);
    rst_in = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    check("midrst_out_data", {24'd0, out_data}, 0);
    check("midrst_flags", {29'd0, out_sof, out_eof, out_parity}, 0);
    check("midrst_in_ready", {31'd0, in_ready}, 0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    fill_unit();
    send(1, 0, 0, 1'b1);

    // back-to-back frames with in_valid held high
    chk_rdy = 1'b1;
    chk_b2b = 1'b1;
    frames_seen = 0;
    fill_rand(2);
    send(2, 0, 0, 1'b0);
    check("b2b_frames", frames_seen, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_encoder_stream.md
Name: rs_encoder_stream

Overview:
- Systematic RS(255,239) encoder over GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D). This is the transmit-side counterpart of the team's RS decoder and uses the same field and polynomial-basis symbol format.
- Accepts k message symbols over a valid/ready stream. Emits the n-symbol codeword: the k message symbols pass through unchanged, followed by 2t parity symbols from a generator-polynomial LFSR.
- Sits between the framing source and the channel/modulator.

Parameters:
- n, 255, codeword length in symbols
- k, 239, message length in symbols
- t, 8, correctable symbol errors; must satisfy n-k = 2t
- m, 8, symbol width in bits
- FCR, 0, first consecutive root; g(x) = prod_{i=0..2t-1} (x - α^(FCR+i))

Ports:
- clk_in  input  1  system clock, rising edge
- rst_in  input  1  asynchronous active-high reset
- in_valid  input  1  message symbol valid
- in_ready  output  1  encoder accepts a message symbol this cycle
- in_data  input  m  message symbol, polynomial basis, highest-degree symbol first
- out_valid  output  1  codeword symbol valid
- out_ready  input  1  downstream accepts a symbol
- out_data  output  m  codeword symbol
- out_sof  output  1  marks codeword symbol 0
- out_eof  output  1  marks codeword symbol n-1
- out_parity  output  1  current symbol is a parity symbol

Behaviour:
- Reset (async, active-high): state=MSG, cnt=0, all 2t parity registers r[0..2t-1]=0, out_valid=0, out_data=0, out_sof=0, out_eof=0, out_parity=0. in_ready is forced 0 while rst_in is high.
- Advance condition: adv = !out_valid | out_ready. There is a single registered output stage, and no data is lost under backpressure.
- State MSG:
  - in_ready = adv.
  - On in_valid & in_ready:
    - fb = in_data ^ r[2t-1]
    - r[0] <= g0·fb; r[i] <= r[i-1] ^ gi·fb for i=1..2t-1
    - out_data <= in_data; out_valid <= 1; out_sof <= (cnt==0); out_parity <= 0
    - if cnt==k-1: cnt <= 0 and state <= PARITY; else cnt <= cnt+1
  - On adv without an input transfer: out_valid <= 0.
- State PARITY:
  - in_ready = 0.
  - Each adv cycle:
    - out_data <= r[2t-1]; out_valid <= 1; out_parity <= 1; out_eof <= (cnt==2t-1)
    - shift r[i] <= r[i-1], r[0] <= 0
    - if cnt==2t-1: cnt <= 0 and state <= MSG; else cnt++
  - Parity is therefore emitted highest-degree first. The registers are all zero after the last shift, so no explicit clear is needed between frames.
- Latency: one cycle from the accepted input to out_valid.
- Steady-state throughput: 255 output cycles per 239 input symbols. in_ready is low for exactly 2t consecutive adv cycles per frame.
- Coefficient multiply: GF constant multiplication only (XOR networks). The gi are the monic generator coefficients, g2t = 1 implied, precomputed as constants.
- Output stability: out_* must hold stable while out_valid & !out_ready.
- Input gaps: an in_valid gap mid-message inserts bubbles only. LFSR state and cnt are held.
- Reset mid-frame: the partial codeword is discarded and the next accepted symbol starts a new frame at cnt=0.
- Counter width: clog2(k). No wrap beyond k-1 or 2t-1.

Decomposition:
- Shared package rs_pkg holds:
  - n, k, t, m, PRIM_POLY=9'h11D, FCR
  - GEN_COEF[0..2t-1] constant array
  - state enum {MSG, PARITY}
  - gf_mul function for models
- One natural sub-module: gf_mul_const (parameter COEF; combinational m-bit constant multiplier), instantiated 2t times via generate.

Test Plan:
- All-zero message (239×0x00) -> 255×0x00 out. out_sof on symbol 0, out_eof on symbol 254, out_parity high for symbols 239–254.
- Message 0x00×238 then 0x01 -> parity symbols equal GEN_COEF[15], GEN_COEF[14], …, GEN_COEF[0] in output order.
- Random messages, out_ready held 1 -> the codeword polynomial evaluates to 0 at α^0..α^15 per the bench model. After a full frame, in_ready deasserts for exactly 16 cycles.
- Random in_valid gaps plus random out_ready backpressure -> output identical to the no-stall reference codeword, no duplicated or dropped symbols, out_data stable while stalled.
- rst_in pulsed at message symbol 100 -> outputs return to reset values asynchronously. The next frame of 0x00×238, 0x01 yields the same parity as the second scenario.
- Back-to-back frames with in_valid constantly 1 -> the second frame starts on the cycle after the first frame's eof. Second-frame parity is correct, proving no residual LFSR state.
